// File: rtl/timer_input_ctrl_pkg.sv
// Shared types and default constants for the seconds-counter input stage.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package timer_pkg;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } run_state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int CLK_HZ         = 50000000;
  // 0.5 s tick period and 20 ms debounce window at CLK_HZ
  localparam int TICK_DIV_DEF   = CLK_HZ / 2;
  localparam int DEB_CYCLES_DEF = CLK_HZ / 50;

endpackage

// File: rtl/timer_input_ctrl_if.sv
// Raw pushbutton inputs and counter-control outputs of the timer front end.
// Latency: none (wiring only).
// Backpressure: none; buttons are free-running levels, outputs are pulses/levels.
interface timer_input_ctrl_if;
  logic btn_run;
  logic btn_dir;
  logic btn_clr;
  logic stop;
  logic a;
  logic clr;
  logic tick;

  // board / testbench side: drives buttons, observes counter controls
  modport master (output btn_run, output btn_dir, output btn_clr,
                  input stop, input a, input clr, input tick);

  // control stage side
  modport slave (input btn_run, input btn_dir, input btn_clr,
                 output stop, output a, output clr, output tick);
endinterface

// File: rtl/timer_input_ctrl_btn_debounce.sv
// Synchronise, debounce and press-edge-detect one raw pushbutton.
// Latency: 2 (sync) + DEB_CYCLES + 1 cycles from a clean raw edge to press.
// Backpressure: none; press is a single-cycle pulse per accepted press.
module btn_debounce import timer_pkg::*; #(
  parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int            CW       = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  // raw level of a released button
  localparam logic          RAW_IDLE = BTN_ACTIVE_LOW;

  logic          sync_q1, sync_q2;
  logic          level;
  logic          stable, stable_d;
  logic [CW-1:0] cnt;

  // pressed = 1 regardless of board polarity
  assign level = sync_q2 ^ RAW_IDLE;

  // two-flop synchroniser, parked at the released level in reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1 <= RAW_IDLE;
      sync_q2 <= RAW_IDLE;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
    end
  end

  // accept a new level only after it has differed from the stable one for DEB_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable <= 1'b0;
      cnt    <= '0;
    end else if (level == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= level;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // one registered pulse on the released->pressed transition of the stable level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/timer_input_ctrl.sv
// Button front end for the up/down seconds counter: run/stop, direction, clear, count tick.
// Latency: button edge to stop/a/clr change is 2 + DEB_CYCLES + 2 cycles; tick every TICK_DIV.
// Backpressure: none. Option TIMER_TICK_RESTART_EN: prescaler restarts on start and on clear.
module timer_input_ctrl import timer_pkg::*; #(
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int DEB_CYCLES     = DEB_CYCLES_DEF,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  timer_input_ctrl_if.slave  bus
);

  localparam int            PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic          run_press, dir_press, clr_press;
  run_state_t    state_q, state_d;
  logic          a_q, clr_q, tick_q;
  logic          restart;
  logic [PW-1:0] pre_q;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_run (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_run), .press(run_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_dir (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_dir), .press(dir_press)
  );
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)) u_clr (
    .clk(clk), .rst(rst), .btn_raw(bus.btn_clr), .press(clr_press)
  );

  // run/stop state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= STOPPED;
    else     state_q <= state_d;
  end

  // run press toggles, clear press forces STOPPED and wins over a simultaneous run press
  always_comb begin
    state_d = state_q;
    if (clr_press) begin
      state_d = STOPPED;
    end else if (run_press) begin
      state_d = (state_q == STOPPED) ? RUNNING : STOPPED;
    end
  end

  // direction toggles on every dir press, untouched by clear or run state
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            a_q <= DIR_UP;
    else if (dir_press) a_q <= ~a_q;
  end

  // one-cycle clear pulse to the counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) clr_q <= 1'b0;
    else     clr_q <= clr_press;
  end

`ifdef TIMER_TICK_RESTART_EN
  // realign the tick period to the start of a run or a clear
  assign restart = clr_press | ((state_q == STOPPED) && (state_d == RUNNING));
`else
  assign restart = 1'b0;
`endif

  // free-running prescaler; tick follows the cycle the count sits at its last value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      tick_q <= (pre_q == PRE_LAST) && !restart;
      if (restart || (pre_q == PRE_LAST)) pre_q <= '0;
      else                                pre_q <= pre_q + 1'b1;
    end
  end

  assign bus.stop = (state_q == STOPPED);
  assign bus.a    = a_q;
  assign bus.clr  = clr_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_timer_input_ctrl.sv
// Directed plus randomized bench for timer_input_ctrl with TICK_DIV=8, DEB_CYCLES=4.
// Latency: n/a.
// Backpressure: n/a.
module tb_timer_input_ctrl;
  import timer_pkg::*;

  localparam int TD  = 8;
  localparam int DEB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  timer_input_ctrl_if bus();

  timer_input_ctrl #(.TICK_DIV(TD), .DEB_CYCLES(DEB), .BTN_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  // reference model: index 0 = run, 1 = dir, 2 = clr
  int  e;          // clock edges since reset release
  int  reload_e;   // edge at which the tick period last restarted
  bit  m_run, m_a, m_clr;
  bit  s1 [3];
  bit  s2 [3];
  bit  stab [3];   // accepted level, 1 = pressed
  int  runlen [3]; // consecutive cycles the synced level disagreed with stab
  bit  acc_d [3];  // a press was accepted at the previous edge
  bit  pq [3];     // press pulse visible between previous edge and this one

  task automatic model_reset();
    e = 0; reload_e = 0;
    m_run = 1'b0; m_a = 1'b1; m_clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s1[i] = 1'b1; s2[i] = 1'b1; stab[i] = 1'b0;
      runlen[i] = 0; acc_d[i] = 1'b0; pq[i] = 1'b0;
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one clock: advance DUT and model, compare every output
  task automatic step();
    logic r [3];
    bit   was_run, lvl, acc, m_tick;
    r[0] = bus.btn_run; r[1] = bus.btn_dir; r[2] = bus.btn_clr;
    @(posedge clk); #1;
    e++;
    was_run = m_run;
    m_clr = pq[2];
    if (pq[2])      m_run = 1'b0;
    else if (pq[0]) m_run = !m_run;
    if (pq[1]) m_a = !m_a;
`ifdef TIMER_TICK_RESTART_EN
    if (pq[2] || (!was_run && m_run)) reload_e = e;
`endif
    m_tick = (e > reload_e) && (((e - reload_e) % TD) == 0);
    for (int i = 0; i < 3; i++) begin
      lvl = !s2[i];
      s2[i] = s1[i];
      s1[i] = r[i];
      pq[i] = acc_d[i];
      acc = 1'b0;
      if (lvl != stab[i]) begin
        runlen[i]++;
        if (runlen[i] == DEB) begin
          stab[i] = lvl;
          runlen[i] = 0;
          acc = lvl;
        end
      end else begin
        runlen[i] = 0;
      end
      acc_d[i] = acc;
    end
    chk("m_stop", bus.stop, !m_run);
    chk("m_a", bus.a, m_a);
    chk("m_clr", bus.clr, m_clr);
    chk("m_tick", bus.tick, m_tick);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int  n;
    int  k;
    bit  found;

    bus.btn_run = 1'b1; bus.btn_dir = 1'b1; bus.btn_clr = 1'b1;
    rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stop", bus.stop, 1'b1);
    chk("rst_a", bus.a, 1'b1);
    chk("rst_clr", bus.clr, 1'b0);
    chk("rst_tick", bus.tick, 1'b0);
    rst = 1'b0;
    model_reset();

    // idle: one tick per 8 cycles
    n = 0;
    for (int i = 0; i < 24; i++) begin
      step();
      if (bus.tick === 1'b1) n++;
    end
    chk_int("tick_count", n, 3);

    // run held 20 cycles: stop falls 8 edges after the raw edge, release does nothing
    bus.btn_run = 1'b0;
    repeat (7) step();
    chk("run_before", bus.stop, 1'b1);
    step();
    chk("run_fall", bus.stop, 1'b0);
    repeat (12) step();
    bus.btn_run = 1'b1;
    repeat (10) step();
    chk("run_release", bus.stop, 1'b0);

    // dir glitch of 3 cycles is rejected, real presses toggle
    bus.btn_dir = 1'b0;
    repeat (3) step();
    bus.btn_dir = 1'b1;
    repeat (10) step();
    chk("dir_glitch", bus.a, 1'b1);
    bus.btn_dir = 1'b0;
    repeat (6) step();
    bus.btn_dir = 1'b1;
    repeat (10) step();
    chk("dir_press1", bus.a, 1'b0);
    bus.btn_dir = 1'b0;
    repeat (6) step();
    bus.btn_dir = 1'b1;
    repeat (10) step();
    chk("dir_press2", bus.a, 1'b1);

    // run and clr together while running: clr wins, single pulse
    bus.btn_run = 1'b0; bus.btn_clr = 1'b0;
    repeat (6) step();
    bus.btn_run = 1'b1; bus.btn_clr = 1'b1;
    step();
    chk("clr_early", bus.clr, 1'b0);
    step();
    chk("clr_pulse", bus.clr, 1'b1);
    chk("clr_stop", bus.stop, 1'b1);
    step();
    chk("clr_width", bus.clr, 1'b0);
    chk("clr_stop_hold", bus.stop, 1'b1);
    repeat (10) step();

    // first tick after a start
    bus.btn_run = 1'b0;
    repeat (6) step();
    bus.btn_run = 1'b1;
    repeat (2) step();
    chk("start_fall", bus.stop, 1'b0);
    k = 0; found = 1'b0;
    for (int i = 1; i <= 16 && !found; i++) begin
      step();
      if (bus.tick === 1'b1) begin
        k = i;
        found = 1'b1;
      end
    end
`ifdef TIMER_TICK_RESTART_EN
    chk_int("first_tick", k, 8);
`else
    chk("first_tick_range", (k >= 1) && (k <= 8), 1'b1);
`endif

    // randomized button activity against the model
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 11) == 0) bus.btn_run = ~bus.btn_run;
      if ($urandom_range(0, 11) == 0) bus.btn_dir = ~bus.btn_dir;
      if ($urandom_range(0, 15) == 0) bus.btn_clr = ~bus.btn_clr;
      step();
    end
    bus.btn_run = 1'b1; bus.btn_dir = 1'b1; bus.btn_clr = 1'b1;
    repeat (20) step();

    // get to RUNNING with a toggled direction, then reset mid-debounce
    if (!m_run) begin
      bus.btn_run = 1'b0;
      repeat (6) step();
      bus.btn_run = 1'b1;
      repeat (10) step();
    end
    chk("pre_rst_run", bus.stop, 1'b0);
    bus.btn_dir = 1'b0;
    repeat (4) step();
    rst = 1'b1;
    #1;
    chk("mid_rst_stop", bus.stop, 1'b1);
    chk("mid_rst_a", bus.a, 1'b1);
    chk("mid_rst_tick", bus.tick, 1'b0);
    chk("mid_rst_clr", bus.clr, 1'b0);
    bus.btn_dir = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    repeat (20) step();
    chk("post_rst_a", bus.a, 1'b1);
    chk("post_rst_stop", bus.stop, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
